divider68by34: RTL
==================

Name: divider68by34

Overview:
- Sequential radix-2 restoring divider; the inverse companion of the 34-bit multiplier.
- Divides a 2W-bit dividend by a W-bit divisor, producing a W-bit quotient and a W-bit remainder.
- Uses the same start/valid_out handshake as the multiplier, so multiply results (P) feed it directly for round-trip checking and for datapath reuse.

Parameters:
- W, 34, operand width; dividend is 2W bits, divisor/quotient/remainder are W bits.

Ports:
- clk  input  1  single clock, rising-edge.
- rst  input  1  reset, asynchronous, active-low.
- start  input  1  request; sampled only when busy=0.
- A  input  2W  dividend; sampled on the accepted start edge.
- B  input  W  divisor; sampled on the accepted start edge.
- Q  output  W  quotient.
- R  output  W  remainder.
- valid_out  output  1  one-cycle pulse; Q/R/flags are valid.
- busy  output  1  high while a division is in progress.
- div_by_zero  output  1  B was 0 for the result being presented.
- overflow  output  1  quotient does not fit in W bits (A[2W-1:W] >= B, B!=0).

Behaviour:
- Reset (rst=0, asynchronous): state=IDLE; Q, R, valid_out, busy, div_by_zero and overflow are all 0; iteration counter is 0.
- States: IDLE, RUN, DONE.
- IDLE:
  - start=1 accepts the request: latch A and B, clear both flags.
  - If B==0: go to DONE with Q=all ones, R=A[W-1:0], div_by_zero=1.
  - Else if A[2W-1:W] >= B: go to DONE with Q=all ones, R=A[W-1:0], overflow=1.
  - Otherwise: partial remainder (W+1 bits) = {0, A[2W-1:W]}; low shift register = A[W-1:0]; counter=W; go to RUN.
- RUN, one quotient bit per cycle:
  - rem = {rem[W-1:0], low MSB}; shift low left by one.
  - If rem >= B: rem -= B, shift in quotient bit 1; else shift in 0.
  - Decrement counter.
  - The iteration that brings the counter to 0 loads Q/R and goes to DONE.
- DONE: valid_out=1 for exactly this one cycle; busy=0; next state is IDLE.
  - A start in this cycle is accepted exactly as in IDLE, so back-to-back operation is supported.
- Latency, counting the accepted start edge as edge 0:
  - Normal division: valid_out is high in the cycle after edge W+1 (W+1 RUN/transition edges). With W=34, valid_out rises 35 edges after start.
  - Error cases: valid_out is high in the cycle after edge 1.
- busy: high in RUN, and high from the start-accept edge until the edge that enters DONE. Low in IDLE and DONE.
- start while busy=1 is ignored. A and B may change freely while busy; internal copies are used.
- Q, R and the flags hold their last values until the next result is loaded; they do not return to 0 after valid_out falls.
- Arithmetic:
  - The comparison and subtraction use W+1 bits, so the shifted remainder carry is not lost.
  - Invariant at DONE for non-error results: A == Q*B + R and R < B.
- rst asserted mid-operation: abort immediately to the reset values. No valid_out is issued for the aborted operation.
- No combinational path from inputs to outputs; all outputs are registered.

Test Plan:
- Round-trip: A=0x0FFFFFFF*0x0FFFFFFF (=0x00FFFFFFE0000001), B=0x0FFFFFFF -> Q=0x0FFFFFFF, R=0, flags 0, valid_out 35 edges after start, single-cycle pulse.
- Small/remainder: A=100, B=7 -> Q=14, R=2. Max case: A=0xFFFFFFFF800000000+0x3FFFFFFFF... i.e. {B-1, all ones} with B=0x3FFFFFFFF -> Q=0x3FFFFFFFF, R=0x3FFFFFFFE, overflow=0.
- Error paths: B=0, A=0x123 -> div_by_zero=1, Q=0x3FFFFFFFF, R=0x123, valid_out after 1 edge. A=5<<34, B=5 -> overflow=1, same timing.
- Handshake: start pulsed again at cycles 3 and 20 of a running division -> ignored, first result unchanged. Start asserted in the valid_out cycle -> second division accepted, its valid_out arrives 35 edges later.
- Reset mid-op: rst=0 at cycle 10 of a division -> all outputs 0 asynchronously, no valid_out. After release, A=100, B=7 completes normally.
- Random regression: 1000 random A/B with B != 0 -> either overflow set, or Q*B+R==A and R<B. Each product P from the multiplier divided by its B returns its A with R=0.

Source files
------------

// File: rtl/divider68by34.sv
// Sequential radix-2 restoring divider: 2W-bit dividend / W-bit divisor -> W-bit quotient and remainder.
// Shares the start/valid_out handshake of the 34-bit multiplier so its products can be fed straight in.
module divider68by34 #(
  parameter int W = 34
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  input  logic [2*W-1:0] A,
  input  logic [W-1:0]   B,
  output logic [W-1:0]   Q,
  output logic [W-1:0]   R,
  output logic           valid_out,
  output logic           busy,
  output logic           div_by_zero,
  output logic           overflow
);

  localparam int CW = $clog2(W + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  state_e        state_q, state_d;
  logic [W:0]    rem_q, rem_d;
  logic [W-1:0]  low_q, low_d;
  logic [W-1:0]  quo_q, quo_d;
  logic [W-1:0]  div_q, div_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [W-1:0]  q_q, q_d;
  logic [W-1:0]  r_q, r_d;
  logic          valid_q, valid_d;
  logic          busy_q, busy_d;
  logic          dbz_q, dbz_d;
  logic          ovf_q, ovf_d;
  logic [W:0]    shifted_s;

  // Next-state and datapath: accept in IDLE/DONE, one quotient bit per RUN cycle.
  always_comb begin
    state_d   = state_q;
    rem_d     = rem_q;
    low_d     = low_q;
    quo_d     = quo_q;
    div_d     = div_q;
    cnt_d     = cnt_q;
    q_d       = q_q;
    r_d       = r_q;
    dbz_d     = dbz_q;
    ovf_d     = ovf_q;
    valid_d   = 1'b0;
    shifted_s = {rem_q[W-1:0], low_q[W-1]};
    case (state_q)
      IDLE, DONE: begin
        // valid_out is the registered image of the DONE cycle.
        valid_d = (state_q == DONE);
        if (start) begin
          div_d = B;
          dbz_d = 1'b0;
          ovf_d = 1'b0;
          if (B == {W{1'b0}}) begin
            q_d     = {W{1'b1}};
            r_d     = A[W-1:0];
            dbz_d   = 1'b1;
            state_d = DONE;
          end else if (A[2*W-1:W] >= B) begin
            q_d     = {W{1'b1}};
            r_d     = A[W-1:0];
            ovf_d   = 1'b1;
            state_d = DONE;
          end else begin
            rem_d   = {1'b0, A[2*W-1:W]};
            low_d   = A[W-1:0];
            quo_d   = {W{1'b0}};
            cnt_d   = CW'(W);
            state_d = RUN;
          end
        end else begin
          state_d = IDLE;
        end
      end
      RUN: begin
        low_d = {low_q[W-2:0], 1'b0};
        if (shifted_s >= {1'b0, div_q}) begin
          rem_d = shifted_s - {1'b0, div_q};
          quo_d = {quo_q[W-2:0], 1'b1};
        end else begin
          rem_d = shifted_s;
          quo_d = {quo_q[W-2:0], 1'b0};
        end
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) begin
          q_d     = quo_d;
          r_d     = rem_d[W-1:0];
          state_d = DONE;
        end else begin
          state_d = RUN;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    busy_d = (state_d == RUN);
  end

  // State and output registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      rem_q   <= '0;
      low_q   <= '0;
      quo_q   <= '0;
      div_q   <= '0;
      cnt_q   <= '0;
      q_q     <= '0;
      r_q     <= '0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      dbz_q   <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      rem_q   <= rem_d;
      low_q   <= low_d;
      quo_q   <= quo_d;
      div_q   <= div_d;
      cnt_q   <= cnt_d;
      q_q     <= q_d;
      r_q     <= r_d;
      valid_q <= valid_d;
      busy_q  <= busy_d;
      dbz_q   <= dbz_d;
      ovf_q   <= ovf_d;
    end
  end

  assign Q           = q_q;
  assign R           = r_q;
  assign valid_out   = valid_q;
  assign busy        = busy_q;
  assign div_by_zero = dbz_q;
  assign overflow    = ovf_q;

endmodule
